// File: rtl/sdram_arbiter_pkg.sv
// rtl/sdram_arbiter_pkg.sv - shared encodings and defaults for the two-master sdram arbiter
package sdram_arbiter_pkg;

    localparam int ADDR_W_DEF  = 24;
    localparam int DATA_W_DEF  = 16;
    localparam int TIMEOUT_DEF = 1023;
    localparam int TIMER_W     = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// rtl/sdram_arbiter_if.sv - master-side, controller-side and status signals of the arbiter
interface sdram_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] m0_address;
    logic [DATA_W-1:0] m0_data_in;
    logic              m0_read_req;
    logic              m0_write_req;
    logic [DATA_W-1:0] m0_data_out;
    logic              m0_read_ack;
    logic              m0_write_ack;
    logic              m0_err;

    logic [ADDR_W-1:0] m1_address;
    logic [DATA_W-1:0] m1_data_in;
    logic              m1_read_req;
    logic              m1_write_req;
    logic [DATA_W-1:0] m1_data_out;
    logic              m1_read_ack;
    logic              m1_write_ack;
    logic              m1_err;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_read_req;
    logic              mem_read_ack;
    logic              mem_write_req;
    logic              mem_write_ack;
    logic              mem_write_en;
    logic              mem_write_latch_address;

    logic [1:0]        grant;
    logic              timeout_flag;
    logic              timeout_clr;

    // Arbiter side: serves the masters, drives the controller.
    modport slave (
        input  m0_address, m0_data_in, m0_read_req, m0_write_req,
        output m0_data_out, m0_read_ack, m0_write_ack, m0_err,
        input  m1_address, m1_data_in, m1_read_req, m1_write_req,
        output m1_data_out, m1_read_ack, m1_write_ack, m1_err,
        output mem_address, mem_data_in, mem_read_req, mem_write_req,
        output mem_write_en, mem_write_latch_address,
        input  mem_data_out, mem_read_ack, mem_write_ack,
        output grant, timeout_flag,
        input  timeout_clr
    );

    modport master (
        output m0_address, m0_data_in, m0_read_req, m0_write_req,
        input  m0_data_out, m0_read_ack, m0_write_ack, m0_err,
        output m1_address, m1_data_in, m1_read_req, m1_write_req,
        input  m1_data_out, m1_read_ack, m1_write_ack, m1_err,
        input  mem_address, mem_data_in, mem_read_req, mem_write_req,
        input  mem_write_en, mem_write_latch_address,
        output mem_data_out, mem_read_ack, mem_write_ack,
        input  grant, timeout_flag,
        output timeout_clr
    );
endinterface

// File: rtl/sdram_arbiter_rr_pick2.sv
// rtl/sdram_arbiter_rr_pick2.sv - combinational round-robin choice between two pending masters
module rr_pick2 (
    input  logic [1:0] pending_i,
    input  logic       last_i,
    output logic       valid_o,
    output logic       idx_o
);
    assign valid_o = |pending_i;
    // On a tie the master not served last wins; otherwise the only pending one.
    assign idx_o   = (pending_i == 2'b11) ? ~last_i : pending_i[1];
endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - round-robin two-master arbiter in front of the single-word sdram port
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    sdram_arbiter_if.slave  bus
);
    localparam logic [TIMER_W-1:0] TIMEOUT_C = TIMER_W'(TIMEOUT);

    logic [1:0] rd_req, wr_req, pending;
    logic       pick_valid, pick_idx;

    assign rd_req  = {bus.m1_read_req,  bus.m0_read_req};
    assign wr_req  = {bus.m1_write_req, bus.m0_write_req};
    assign pending = rd_req | wr_req;

    state_e             state_q;
    op_e                op_q;
    logic               owner_q;
    logic               last_q;
    logic [TIMER_W-1:0] timer_q;
    logic [ADDR_W-1:0]  mem_address_q;
    logic [DATA_W-1:0]  mem_data_in_q;
    logic               mem_rd_q;
    logic               mem_wr_q;
    logic [1:0]         grant_q;
    logic [1:0]         rd_ack_q;
    logic [1:0]         wr_ack_q;
    logic [1:0]         err_q;
    logic [DATA_W-1:0]  data_out_q [2];
    logic               timeout_flag_q;

    rr_pick2 u_pick (
        .pending_i (pending),
        .last_i    (last_q),
        .valid_o   (pick_valid),
        .idx_o     (pick_idx)
    );

    logic              ack_match;
    logic              served_req;
    logic [ADDR_W-1:0] win_address;
    logic [DATA_W-1:0] win_data;

    // Only the ack of the operation in flight counts; the other one is ignored.
    assign ack_match   = (op_q == OP_WR) ? bus.mem_write_ack : bus.mem_read_ack;
    assign served_req  = (op_q == OP_WR) ? wr_req[owner_q] : rd_req[owner_q];
    assign win_address = pick_idx ? bus.m1_address : bus.m0_address;
    assign win_data    = pick_idx ? bus.m1_data_in : bus.m0_data_in;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q        <= ST_IDLE;
            op_q           <= OP_RD;
            owner_q        <= 1'b0;
            last_q         <= 1'b1;
            timer_q        <= '0;
            mem_address_q  <= '0;
            mem_data_in_q  <= '0;
            mem_rd_q       <= 1'b0;
            mem_wr_q       <= 1'b0;
            grant_q        <= 2'b00;
            rd_ack_q       <= 2'b00;
            wr_ack_q       <= 2'b00;
            err_q          <= 2'b00;
            data_out_q[0]  <= '0;
            data_out_q[1]  <= '0;
            timeout_flag_q <= 1'b0;
        end else begin
            // A timeout raised below in the same cycle overrides this clear.
            if (bus.timeout_clr) begin
                timeout_flag_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        owner_q       <= pick_idx;
                        mem_address_q <= win_address;
                        mem_data_in_q <= win_data;
                        timer_q       <= '0;
                        grant_q       <= onehot2(pick_idx);
                        state_q       <= ST_BUSY;
                        // Write takes priority; a simultaneous read stays pending.
                        if (wr_req[pick_idx]) begin
                            op_q     <= OP_WR;
                            mem_wr_q <= 1'b1;
                        end else begin
                            op_q     <= OP_RD;
                            mem_rd_q <= 1'b1;
                        end
                    end
                end
                ST_BUSY: begin
                    timer_q <= timer_q + 1'b1;
                    if (ack_match || timer_q == TIMEOUT_C) begin
                        mem_rd_q <= 1'b0;
                        mem_wr_q <= 1'b0;
                        state_q  <= ST_DONE;
                        if (op_q == OP_WR) begin
                            wr_ack_q[owner_q] <= 1'b1;
                        end else begin
                            rd_ack_q[owner_q] <= 1'b1;
                        end
                        if (ack_match) begin
                            if (op_q == OP_RD) begin
                                data_out_q[owner_q] <= bus.mem_data_out;
                            end
                        end else begin
                            err_q[owner_q] <= 1'b1;
                            timeout_flag_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (!served_req && !bus.mem_read_ack && !bus.mem_write_ack) begin
                        rd_ack_q <= 2'b00;
                        wr_ack_q <= 2'b00;
                        err_q    <= 2'b00;
                        grant_q  <= 2'b00;
                        last_q   <= owner_q;
                        state_q  <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_address             = mem_address_q;
    assign bus.mem_data_in             = mem_data_in_q;
    assign bus.mem_read_req            = mem_rd_q;
    assign bus.mem_write_req           = mem_wr_q;
    assign bus.mem_write_en            = 1'b0;
    assign bus.mem_write_latch_address = 1'b0;
    assign bus.grant                   = grant_q;
    assign bus.timeout_flag            = timeout_flag_q;
    assign bus.m0_data_out             = data_out_q[0];
    assign bus.m0_read_ack             = rd_ack_q[0];
    assign bus.m0_write_ack            = wr_ack_q[0];
    assign bus.m0_err                  = err_q[0];
    assign bus.m1_data_out             = data_out_q[1];
    assign bus.m1_read_ack             = rd_ack_q[1];
    assign bus.m1_write_ack            = wr_ack_q[1];
    assign bus.m1_err                  = err_q[1];

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - randomized and directed bench for sdram_arbiter with a transaction-level model
module tb_sdram_arbiter;
    localparam int TMO = 1023;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sdram_arbiter_if #(.ADDR_W(24), .DATA_W(16)) bus ();

    sdram_arbiter #(.ADDR_W(24), .DATA_W(16), .TIMEOUT(TMO)) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Master-side stimulus, copied onto the interface each step.
    logic        rq_rd [2];
    logic        rq_wr [2];
    logic [23:0] ad [2];
    logic [15:0] dd [2];
    logic        clr = 1'b0;

    task automatic apply();
        bus.m0_read_req  = rq_rd[0];
        bus.m0_write_req = rq_wr[0];
        bus.m0_address   = ad[0];
        bus.m0_data_in   = dd[0];
        bus.m1_read_req  = rq_rd[1];
        bus.m1_write_req = rq_wr[1];
        bus.m1_address   = ad[1];
        bus.m1_data_in   = dd[1];
        bus.timeout_clr  = clr;
    endtask

    task automatic step();
        apply();
        @(posedge clk);
        #3;
    endtask

    function automatic logic ack_r(input int n);
        return (n == 1) ? bus.m1_read_ack : bus.m0_read_ack;
    endfunction
    function automatic logic ack_w(input int n);
        return (n == 1) ? bus.m1_write_ack : bus.m0_write_ack;
    endfunction
    function automatic logic [23:0] rnd_addr();
        return {20'h0, 4'($urandom)};
    endfunction

    // Controller stub: acks a request after st_lat cycles, holds until the req drops.
    logic [15:0] mem_arr [logic [23:0]];
    bit st_hang = 0;
    bit st_fixed = 1;
    int st_lat = 5;
    int st_cnt = 0;

    initial begin
        bus.mem_read_ack  = 1'b0;
        bus.mem_write_ack = 1'b0;
        bus.mem_data_out  = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mem_read_ack || bus.mem_write_ack) begin
                if (!bus.mem_read_req && !bus.mem_write_req) begin
                    bus.mem_read_ack  = 1'b0;
                    bus.mem_write_ack = 1'b0;
                end
            end else begin
                bus.mem_data_out = 16'($urandom);
                if (bus.mem_read_req || bus.mem_write_req) begin
                    st_cnt++;
                    if (!st_hang && st_cnt >= st_lat) begin
                        if (bus.mem_write_req) begin
                            mem_arr[bus.mem_address] = bus.mem_data_in;
                            bus.mem_write_ack = 1'b1;
                        end else begin
                            bus.mem_data_out = mem_arr.exists(bus.mem_address) ?
                                mem_arr[bus.mem_address] : (bus.mem_address[15:0] ^ 16'h5a5a);
                            bus.mem_read_ack = 1'b1;
                        end
                        st_cnt = 0;
                        st_lat = st_fixed ? 5 : int'($urandom_range(1, 6));
                    end
                end else begin
                    st_cnt = 0;
                end
            end
        end
    end

    // Reference: one record for the transaction in flight plus round-robin memory.
    bit          t_valid, t_who, t_wr, t_done, t_abrt;
    int          t_waited;
    bit          m_last, m_flag;
    logic [23:0] e_addr;
    logic [15:0] e_wdata;
    logic [15:0] e_rdata [2];
    bit   [1:0]  m_pend;
    bit          m_w, m_served;

    task automatic model_step();
        if (!rst_n) begin
            t_valid = 0; t_who = 0; t_wr = 0; t_done = 0; t_abrt = 0; t_waited = 0;
            m_last = 1; m_flag = 0; e_addr = 0; e_wdata = 0;
            e_rdata[0] = 0; e_rdata[1] = 0;
            return;
        end
        if (bus.timeout_clr) m_flag = 0;
        if (!t_valid) begin
            m_pend = {bus.m1_read_req | bus.m1_write_req, bus.m0_read_req | bus.m0_write_req};
            if (m_pend != 2'b00) begin
                m_w = (m_pend == 2'b11) ? ~m_last : m_pend[1];
                t_valid = 1; t_who = m_w; t_done = 0; t_abrt = 0; t_waited = 0;
                t_wr    = m_w ? bus.m1_write_req : bus.m0_write_req;
                e_addr  = m_w ? bus.m1_address : bus.m0_address;
                e_wdata = m_w ? bus.m1_data_in : bus.m0_data_in;
            end
        end else if (!t_done) begin
            if (t_wr ? bus.mem_write_ack : bus.mem_read_ack) begin
                t_done = 1;
                if (!t_wr) e_rdata[t_who] = bus.mem_data_out;
            end else if (t_waited == TMO) begin
                t_done = 1; t_abrt = 1; m_flag = 1;
            end
            t_waited++;
        end else begin
            if (t_wr) m_served = t_who ? bus.m1_write_req : bus.m0_write_req;
            else      m_served = t_who ? bus.m1_read_req : bus.m0_read_req;
            if (!m_served && !bus.mem_read_ack && !bus.mem_write_ack) begin
                t_valid = 0;
                m_last = t_who;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    bit cmp_en = 0;
    logic [12:0] exp_ctl, got_ctl;
    bit fin;

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            fin = t_valid && t_done;
            exp_ctl = {t_valid && !t_done && !t_wr, t_valid && !t_done && t_wr,
                       t_valid && t_who, t_valid && !t_who,
                       fin && !t_wr && !t_who, fin && t_wr && !t_who, fin && t_abrt && !t_who,
                       fin && !t_wr && t_who,  fin && t_wr && t_who,  fin && t_abrt && t_who,
                       m_flag, 1'b0, 1'b0};
            got_ctl = {bus.mem_read_req, bus.mem_write_req, bus.grant,
                       bus.m0_read_ack, bus.m0_write_ack, bus.m0_err,
                       bus.m1_read_ack, bus.m1_write_ack, bus.m1_err,
                       bus.timeout_flag, bus.mem_write_en, bus.mem_write_latch_address};
            chk("cyc ctl", got_ctl, exp_ctl);
            chk("cyc mem_address", bus.mem_address, e_addr);
            chk("cyc mem_data_in", bus.mem_data_in, e_wdata);
            chk("cyc m0_data_out", bus.m0_data_out, e_rdata[0]);
            chk("cyc m1_data_out", bus.m1_data_out, e_rdata[1]);
        end
    end

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 60 && (bus.grant != 2'b00 || bus.m0_read_ack || bus.m0_write_ack
                                   || bus.m1_read_ack || bus.m1_write_ack); i++) step();
        chk(nm, bus.grant, 2'b00);
    endtask

    task automatic run_timeout(input bit clr_hold);
        int n;
        st_hang = 1;
        clr = clr_hold;
        ad[0] = 24'h000333;
        rq_rd[0] = 1;
        n = 0;
        for (int i = 0; i < 1200 && !bus.m0_read_ack; i++) begin
            step();
            if (bus.mem_read_req) n++;
        end
        chk("tmo req cycles", n, TMO + 1);
        chk("tmo m0_read_ack", bus.m0_read_ack, 1);
        chk("tmo m0_err", bus.m0_err, 1);
        chk("tmo mem_read_req low", bus.mem_read_req, 0);
        chk("tmo flag set", bus.timeout_flag, 1);
        if (clr_hold) begin
            step();
            chk("tmo flag cleared by held clr", bus.timeout_flag, 0);
            clr = 0;
        end else begin
            rq_rd[0] = 0;
            step(); step(); step();
            chk("tmo flag sticky", bus.timeout_flag, 1);
            clr = 1;
            step();
            clr = 0;
            chk("tmo flag cleared", bus.timeout_flag, 0);
        end
        rq_rd[0] = 0;
        st_hang = 0;
        wait_idle("tmo idle");
    endtask

    logic [1:0] got_g [6];
    logic [1:0] exp_g [6];
    logic [1:0] prev_g;
    int ng, ack_step, served;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int n = 0; n < 2; n++) begin
            rq_rd[n] = 0; rq_wr[n] = 0; ad[n] = 0; dd[n] = 0;
        end
        rst_n = 0;
        step(); step(); step();
        chk("rst grant", bus.grant, 2'b00);
        chk("rst mem reqs", {bus.mem_read_req, bus.mem_write_req}, 2'b00);
        chk("rst acks", {bus.m0_read_ack, bus.m0_write_ack, bus.m1_read_ack, bus.m1_write_ack}, 4'h0);
        chk("rst flag", bus.timeout_flag, 0);
        chk("rst mem_address", bus.mem_address, 24'h0);
        chk("rst m0_data_out", bus.m0_data_out, 16'h0);
        rst_n = 1;
        cmp_en = 1;
        step();

        // Master 0 write, controller latency 5
        st_fixed = 1; st_lat = 5;
        ad[0] = 24'h000010; dd[0] = 16'h1234; rq_wr[0] = 1;
        for (int i = 0; i < 20 && !bus.mem_write_req; i++) step();
        chk("w0 mem_write_req", bus.mem_write_req, 1);
        chk("w0 mem_address", bus.mem_address, 24'h000010);
        chk("w0 mem_data_in", bus.mem_data_in, 16'h1234);
        chk("w0 grant", bus.grant, 2'b01);
        ad[0] = 24'hFFFFFF; dd[0] = 16'h0000;
        step();
        chk("w0 address latched", bus.mem_address, 24'h000010);
        chk("w0 data latched", bus.mem_data_in, 16'h1234);
        ack_step = 0;
        for (int i = 0; i < 20 && !bus.mem_write_ack; i++) step();
        chk("w0 mem_write_ack seen", bus.mem_write_ack, 1);
        chk("w0 m0_write_ack not yet", bus.m0_write_ack, 0);
        step();
        chk("w0 m0_write_ack", bus.m0_write_ack, 1);
        chk("w0 mem_write_req dropped", bus.mem_write_req, 0);
        chk("w0 m0_err", bus.m0_err, 0);
        chk("w0 stored", mem_arr[24'h000010], 16'h1234);
        rq_wr[0] = 0;
        wait_idle("w0 idle");

        // Master 1 read
        mem_arr[24'h00ABCD] = 16'hBEEF;
        ad[1] = 24'h00ABCD; rq_rd[1] = 1;
        for (int i = 0; i < 40 && !bus.m1_read_ack; i++) step();
        chk("r1 m1_read_ack", bus.m1_read_ack, 1);
        chk("r1 grant", bus.grant, 2'b10);
        for (int i = 0; i < 3; i++) begin
            chk("r1 m1_data_out held", bus.m1_data_out, 16'hBEEF);
            chk("r1 m1_err", bus.m1_err, 0);
            step();
        end
        chk("r1 ack held", bus.m1_read_ack, 1);
        rq_rd[1] = 0;
        wait_idle("r1 idle");

        // Both masters continuously requesting
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        ng = 0;
        prev_g = 2'b00;
        rq_rd[0] = 1; rq_rd[1] = 1;
        for (int i = 0; i < 300 && ng < 6; i++) begin
            step();
            if (bus.grant != 2'b00 && prev_g == 2'b00) begin
                got_g[ng] = bus.grant;
                ng++;
            end
            prev_g = bus.grant;
            for (int n = 0; n < 2; n++) begin
                if (ack_r(n)) rq_rd[n] = 0;
                else if (!rq_rd[n]) rq_rd[n] = 1;
            end
        end
        chk("rr grant count", ng, 6);
        for (int i = 0; i < 6; i++) chk($sformatf("rr grant %0d", i), got_g[i], exp_g[i]);
        rq_rd[0] = 0; rq_rd[1] = 0;
        wait_idle("rr idle");

        run_timeout(1'b0);
        run_timeout(1'b1);

        // Read and write together from master 0
        ad[0] = 24'h000020; dd[0] = 16'h5555;
        rq_wr[0] = 1; rq_rd[0] = 1;
        for (int i = 0; i < 20 && !bus.mem_write_req && !bus.mem_read_req; i++) step();
        chk("rw write first", {bus.mem_write_req, bus.mem_read_req}, 2'b10);
        for (int i = 0; i < 40 && !bus.m0_write_ack; i++) step();
        chk("rw write ack", bus.m0_write_ack, 1);
        chk("rw no read ack", bus.m0_read_ack, 0);
        rq_wr[0] = 0;
        for (int i = 0; i < 20 && !bus.mem_read_req; i++) step();
        chk("rw read issued", bus.mem_read_req, 1);
        chk("rw read address", bus.mem_address, 24'h000020);
        for (int i = 0; i < 40 && !bus.m0_read_ack; i++) step();
        chk("rw read ack", bus.m0_read_ack, 1);
        chk("rw read data", bus.m0_data_out, 16'h5555);
        rq_rd[0] = 0;
        wait_idle("rw idle");

        // Reset while BUSY
        st_hang = 1;
        ad[1] = 24'h000777; dd[1] = 16'h7777; rq_wr[1] = 1;
        for (int i = 0; i < 20 && !bus.mem_write_req; i++) step();
        step(); step(); step();
        chk("mr busy", bus.mem_write_req, 1);
        rst_n = 0;
        step();
        chk("mr grant", bus.grant, 2'b00);
        chk("mr mem reqs", {bus.mem_read_req, bus.mem_write_req}, 2'b00);
        chk("mr mem_address", bus.mem_address, 24'h0);
        chk("mr acks", {bus.m1_write_ack, bus.m1_err, bus.timeout_flag}, 3'b000);
        rst_n = 1;
        rq_wr[1] = 0;
        st_hang = 0;
        step();
        ad[0] = 24'h000010; rq_rd[0] = 1;
        for (int i = 0; i < 40 && !bus.m0_read_ack; i++) step();
        chk("mr regrant ack", bus.m0_read_ack, 1);
        chk("mr regrant grant", bus.grant, 2'b01);
        chk("mr regrant data", bus.m0_data_out, 16'h1234);
        rq_rd[0] = 0;
        wait_idle("mr idle");

        // Randomized traffic
        st_fixed = 0;
        served = 0;
        for (int c = 0; c < 4000; c++) begin
            step();
            clr = ($urandom_range(0, 19) == 0);
            for (int n = 0; n < 2; n++) begin
                if (rq_rd[n] || rq_wr[n]) begin
                    if (ack_w(n) && rq_wr[n]) begin
                        if ($urandom_range(0, 3) != 0) begin rq_wr[n] = 0; served++; end
                    end else if (ack_r(n) && rq_rd[n]) begin
                        if ($urandom_range(0, 3) != 0) begin rq_rd[n] = 0; served++; end
                    end
                    if ($urandom_range(0, 9) == 0) begin
                        ad[n] = rnd_addr(); dd[n] = 16'($urandom);
                    end
                end else if (!ack_r(n) && !ack_w(n) && $urandom_range(0, 2) == 0) begin
                    ad[n] = rnd_addr(); dd[n] = 16'($urandom);
                    case ($urandom_range(0, 9))
                        0:          begin rq_rd[n] = 1; rq_wr[n] = 1; end
                        1, 2, 3, 4: rq_wr[n] = 1;
                        default:    rq_rd[n] = 1;
                    endcase
                end
            end
        end
        chk("rand progress", served > 100, 1);
        clr = 0;
        for (int n = 0; n < 2; n++) begin rq_rd[n] = 0; rq_wr[n] = 0; end
        wait_idle("rand idle");
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
